auto_player: RTL and testbench

//  Computer opponent that drives the left/right button interface of a paddle

---
 rtl/auto_player.sv | 124 ++++++++++++
 tb/tb_auto_player.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/auto_player.sv
// Computer paddle opponent: compares ball column with paddle position and emits
// one press/release pulse per step, followed by an optional reaction pause.
module auto_player #(
  parameter int BIT_WIDTH      = 3,
  parameter int SIZE           = 2,
  parameter int PRESS_CYCLES   = 2,
  parameter int RELEASE_CYCLES = 2,
  parameter int REACT_DELAY    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 ball_valid,
  input  logic [BIT_WIDTH-1:0] ball_col,
  input  logic [BIT_WIDTH-1:0] state_left,
  output logic                 left,
  output logic                 right,
  output logic                 busy
);
  localparam int CNT_MAX_A = (PRESS_CYCLES > RELEASE_CYCLES) ? PRESS_CYCLES : RELEASE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > REACT_DELAY) ? CNT_MAX_A : REACT_DELAY;
  localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] P_LAST = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RELEASE_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST = CW'((REACT_DELAY > 0) ? REACT_DELAY - 1 : 0);

  localparam logic [BIT_WIDTH-1:0] MIN_LEFT = BIT_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0] MAX_LEFT = BIT_WIDTH'(2**BIT_WIDTH - 1 - SIZE);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE, S_WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_left, r_right, r_busy;
  logic            w_left_nxt, w_right_nxt;
  logic [BIT_WIDTH:0] w_redge;
  logic            w_want_left, w_want_right;

  // Right edge is one bit wider so a paddle at the far edge cannot wrap.
  assign w_redge      = {1'b0, state_left} + (BIT_WIDTH+1)'(SIZE - 1);
  assign w_want_left  = (ball_col < state_left) && (state_left != MIN_LEFT);
  assign w_want_right = ({1'b0, ball_col} > w_redge) && (state_left != MAX_LEFT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_left_nxt  = r_left;
    w_right_nxt = r_right;
    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_left_nxt  = 1'b0;
      w_right_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt   = '0;
          w_left_nxt  = 1'b0;
          w_right_nxt = 1'b0;
          if (ball_valid && w_want_left) begin
            w_state_nxt = S_PRESS;
            w_left_nxt  = 1'b1;
          end else if (ball_valid && w_want_right) begin
            w_state_nxt = S_PRESS;
            w_right_nxt = 1'b1;
          end
        end
        S_PRESS: begin
          if (r_cnt == P_LAST) begin
            w_state_nxt = S_RELEASE;
            w_cnt_nxt   = '0;
            w_left_nxt  = 1'b0;
            w_right_nxt = 1'b0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          if (r_cnt == R_LAST) begin
            w_state_nxt = (REACT_DELAY == 0) ? S_IDLE : S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (r_cnt == W_LAST) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_left_nxt  = 1'b0;
          w_right_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_left  <= w_left_nxt;
      r_right <= w_right_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign left  = r_left;
  assign right = r_right;
  assign busy  = r_busy;
endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: timeline model checked every cycle, directed literal
// scenarios, and a closed loop with a simple paddle tracker.
module tb_auto_player;
  localparam int BW  = 3;
  localparam int SZ  = 2;
  localparam int P   = 2;
  localparam int R   = 2;
  localparam int D   = 4;
  localparam int TOT = P + R + D;
  localparam int MAXL = (1 << BW) - 1 - SZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          ball_valid = 1'b0;
  logic [BW-1:0] ball_col = '0;
  logic [BW-1:0] sl_drv = 3'd3;
  logic [BW-1:0] state_left;
  logic          left, right, busy;

  logic          loop_mode = 1'b0;
  logic          trk_load = 1'b0;
  logic [BW-1:0] trk_pos;
  logic          trk_pl, trk_pr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign state_left = loop_mode ? trk_pos : sl_drv;

  auto_player #(.BIT_WIDTH(BW), .SIZE(SZ), .PRESS_CYCLES(P),
                .RELEASE_CYCLES(R), .REACT_DELAY(D)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ball_valid(ball_valid),
    .ball_col(ball_col), .state_left(state_left),
    .left(left), .right(right), .busy(busy)
  );

  // Tracker: one paddle step per rising edge of a button.
  always @(posedge clk) begin
    if (trk_load) trk_pos <= 3'd3;
    else if (left && !trk_pl && trk_pos > 0) trk_pos <= trk_pos - 1'b1;
    else if (right && !trk_pr && int'(trk_pos) < (1 << BW) - SZ) trk_pos <= trk_pos + 1'b1;
    trk_pl <= left;
    trk_pr <= right;
  end

  // Model: age = edges since the last accepted press; idle once age reaches TOT.
  int   age = TOT;
  bit   mdir_l = 1'b0;
  logic m_wl, m_wr, exp_l, exp_r, exp_b;
  assign m_wl = (int'(ball_col) < int'(state_left)) && (int'(state_left) != 1);
  assign m_wr = (int'(ball_col) > int'(state_left) + SZ - 1) && (int'(state_left) != MAXL);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age    <= TOT;
      mdir_l <= 1'b0;
    end else if (!en) begin
      age <= TOT;
    end else if (age >= TOT && ball_valid && (m_wl || m_wr)) begin
      age    <= 0;
      mdir_l <= m_wl;
    end else if (age < TOT) begin
      age <= age + 1;
    end
  end

  assign exp_b = (age < TOT);
  assign exp_l = mdir_l && (age < P);
  assign exp_r = !mdir_l && (age < P);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_left", 32'(left), 32'(exp_l));
      chk("model_right", 32'(right), 32'(exp_r));
      chk("model_busy", 32'(busy), 32'(exp_b));
      chk("exclusive", 32'(left && right), 32'd0);
    end
  end

  logic [15:0] lh, rh, bh;
  task automatic win(input int n);
    lh = '0; rh = '0; bh = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lh[i] = left; rh[i] = right; bh[i] = busy;
    end
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int rises;
    logic prev_l;
    #12;
    chk("reset_left", 32'(left), 32'd0);
    chk("reset_right", 32'(right), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // chase left: pulse 2 high, then 6 busy-low-output cycles, next press 9 later
    sl_drv = 3'd4; ball_col = 3'd1; en = 1'b1; ball_valid = 1'b1;
    win(10);
    chk("left_seq", 32'(lh[9:0]), 32'h203);
    chk("left_busy", 32'(bh[9:0]), 32'h2FF);
    chk("left_no_right", 32'(rh[9:0]), 32'd0);
    go_idle();

    // chase right
    sl_drv = 3'd2; ball_col = 3'd6; en = 1'b1;
    win(4);
    chk("right_seq", 32'(rh[3:0]), 32'h3);
    chk("right_no_left", 32'(lh[3:0]), 32'd0);
    go_idle();

    // ball under paddle, paddle at min, paddle at max
    sl_drv = 3'd3; ball_col = 3'd4; en = 1'b1;
    win(3);
    chk("in_range", 32'({lh[2:0], rh[2:0], bh[2:0]}), 32'd0);
    sl_drv = 3'd1; ball_col = 3'd0;
    win(3);
    chk("at_min", 32'({lh[2:0], rh[2:0], bh[2:0]}), 32'd0);
    sl_drv = 3'd5; ball_col = 3'd7;
    win(3);
    chk("at_max", 32'({lh[2:0], rh[2:0], bh[2:0]}), 32'd0);

    // ball_valid low blocks decision
    sl_drv = 3'd4; ball_col = 3'd1; ball_valid = 1'b0;
    win(3);
    chk("invalid_ball", 32'({lh[2:0], rh[2:0], bh[2:0]}), 32'd0);

    // en drop on the second press cycle, then re-decide
    ball_valid = 1'b1;
    lh = '0; bh = '0;
    @(negedge clk); lh[0] = left; bh[0] = busy;
    @(negedge clk); lh[1] = left; bh[1] = busy;
    en = 1'b0;
    @(negedge clk); lh[2] = left; bh[2] = busy;
    en = 1'b1;
    @(negedge clk); lh[3] = left; bh[3] = busy;
    chk("en_drop_left", 32'(lh[3:0]), 32'hB);
    chk("en_drop_busy", 32'(bh[3:0]), 32'hB);
    go_idle();
    @(negedge clk);

    // async reset mid-press
    sl_drv = 3'd2; ball_col = 3'd6; en = 1'b1;
    @(negedge clk);
    chk("pre_reset_right", 32'(right), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_right", 32'(right), 32'd0);
    chk("async_left", 32'(left), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("post_reset_idle", 32'({right, busy}), 32'd0);
    @(negedge clk);
    chk("first_decision", 32'(right), 32'd1);
    go_idle();
    @(negedge clk);

    // closed loop: paddle from 3 to 1 in two left pulses
    trk_load = 1'b1; ball_col = 3'd0;
    @(negedge clk);
    @(negedge clk);
    trk_load = 1'b0; loop_mode = 1'b1; en = 1'b1; ball_valid = 1'b1;
    rises = 0; prev_l = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (left && !prev_l) rises++;
      prev_l = left;
    end
    chk("loop_rises", 32'(rises), 32'd2);
    chk("loop_pos", 32'(trk_pos), 32'd1);
    chk("loop_idle", 32'({left, right, busy}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
